// File: rtl/relu_backward.sv
// relu_backward: gradient-side counterpart of the ReLU stage.
// Forward elements push one mask bit each (1 when the sign bit is clear).
// Backward gradients pop the mask in the same order.
// A gradient is passed when its mask bit is 1 and zeroed when it is 0.
// The result leaves through a single registered valid/ready slot.
module relu_backward #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 1024,
    parameter int pADDR_WIDTH = $clog2(pDEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          fwd_valid,
    input  logic signed [pDATA_WIDTH-1:0] fwd_data,
    output logic                          fwd_ready,
    input  logic                          grad_in_valid,
    input  logic signed [pDATA_WIDTH-1:0] grad_in_data,
    output logic                          grad_in_ready,
    output logic                          grad_out_valid,
    output logic signed [pDATA_WIDTH-1:0] grad_out_data,
    input  logic                          grad_out_ready,
    output logic [pADDR_WIDTH:0]          count,
    output logic                          full,
    output logic                          empty
);

    logic                          r_mask [pDEPTH];
    logic [pADDR_WIDTH-1:0]        r_wr_ptr;
    logic [pADDR_WIDTH-1:0]        r_rd_ptr;
    logic [pADDR_WIDTH:0]          r_count;
    logic                          r_out_valid;
    logic signed [pDATA_WIDTH-1:0] r_out_data;

    logic w_full;
    logic w_empty;
    logic w_slot_can_load;
    logic w_fwd_ready;
    logic w_grad_in_ready;
    logic w_push;
    logic w_pop;
    logic w_mask_bit;

    // Status flags, handshakes and the mask bit at the read pointer.
    // Readiness uses the registered count only, so there is no push-to-pop bypass.
    always_comb begin
        w_full          = (r_count == (pADDR_WIDTH+1)'(pDEPTH));
        w_empty         = (r_count == '0);
        w_slot_can_load = !r_out_valid || grad_out_ready;
        w_fwd_ready     = !w_full && !flush;
        w_grad_in_ready = !w_empty && !flush && w_slot_can_load;
        w_push          = fwd_valid && w_fwd_ready;
        w_pop           = grad_in_valid && w_grad_in_ready;
        w_mask_bit      = r_mask[r_rd_ptr];
    end

    // Mask storage: write the inverted sign bit on each accepted forward element.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mask[r_wr_ptr] <= ~fwd_data[pDATA_WIDTH-1];
        end
    end

    // Pointers and occupancy. The pointers wrap naturally because pDEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output slot: load the masked gradient on a transfer.
    // Clear valid once downstream has taken it. Flush does not disturb the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mask_bit ? grad_in_data : '0;
        end else if (r_out_valid && grad_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Drive the output ports from the registered state and the handshake terms.
    always_comb begin
        fwd_ready      = w_fwd_ready;
        grad_in_ready  = w_grad_in_ready;
        grad_out_valid = r_out_valid;
        grad_out_data  = r_out_data;
        count          = r_count;
        full           = w_full;
        empty          = w_empty;
    end

endmodule

// File: tb/tb_relu_backward.sv
// Directed self-checking bench for relu_backward.
// Inputs change 1 ns after the rising edge. Outputs are checked 1-2 ns after it.
module tb_relu_backward;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          fwd_valid;
    logic [DW-1:0] fwd_data;
    logic          fwd_ready;
    logic          grad_in_valid;
    logic [DW-1:0] grad_in_data;
    logic          grad_in_ready;
    logic          grad_out_valid;
    logic [DW-1:0] grad_out_data;
    logic          grad_out_ready;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int n_checks = 0;
    int n_errors = 0;
    logic mq[$];

    always #5 clk = ~clk;

    relu_backward #(
        .pDATA_WIDTH(DW),
        .pDEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .fwd_valid(fwd_valid),
        .fwd_data(fwd_data),
        .fwd_ready(fwd_ready),
        .grad_in_valid(grad_in_valid),
        .grad_in_data(grad_in_data),
        .grad_in_ready(grad_in_ready),
        .grad_out_valid(grad_out_valid),
        .grad_out_data(grad_out_data),
        .grad_out_ready(grad_out_ready),
        .count(count),
        .full(full),
        .empty(empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] g;
        logic [DW-1:0] e;
        logic          m;
        logic [DW-1:0] fv [4];
        logic [DW-1:0] gv [4];
        logic [DW-1:0] ev [4];

        rst = 1'b1; flush = 1'b0; fwd_valid = 1'b0; fwd_data = '0;
        grad_in_valid = 1'b0; grad_in_data = '0; grad_out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_fwd_ready", fwd_ready, 1);
        chk("rst_valid", grad_out_valid, 0);
        chk("rst_data", grad_out_data, 0);

        // Sign mapping
        fv[0] = 32'd5;   fv[1] = 32'hFFFF_FFFD; fv[2] = 32'd0;   fv[3] = 32'h8000_0000;
        gv[0] = 32'd100; gv[1] = 32'd200;       gv[2] = 32'd300; gv[3] = 32'd400;
        ev[0] = 32'd100; ev[1] = 32'd0;         ev[2] = 32'd300; ev[3] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            fwd_valid = 1'b1; fwd_data = fv[i];
            tick();
        end
        fwd_valid = 1'b0;
        #1;
        chk("sign_count4", count, 4);
        grad_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            grad_in_valid = 1'b1; grad_in_data = gv[i];
            #1;
            chk("sign_in_ready", grad_in_ready, 1);
            tick();
            chk("sign_out_valid", grad_out_valid, 1);
            chk("sign_out_data", grad_out_data, ev[i]);
        end
        grad_in_valid = 1'b0;
        tick();
        chk("sign_valid_drop", grad_out_valid, 0);
        chk("sign_count0", count, 0);
        chk("sign_empty", empty, 1);

        // Fill to full, refused push, drain
        for (int i = 0; i < DEPTH; i++) begin
            fwd_valid = 1'b1; fwd_data = DW'(i + 1);
            tick();
        end
        fwd_valid = 1'b0;
        #1;
        chk("fill_count", count, DEPTH);
        chk("fill_full", full, 1);
        chk("fill_fwd_ready", fwd_ready, 0);
        fwd_valid = 1'b1; fwd_data = 32'd1;
        #1;
        chk("full_refuse_ready", fwd_ready, 0);
        tick();
        fwd_valid = 1'b0;
        chk("full_refuse_count", count, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            grad_in_valid = 1'b1; grad_in_data = 32'd7;
            tick();
            chk("drain_data", grad_out_data, 7);
        end
        grad_in_valid = 1'b0;
        tick();
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);

        // Empty blocking
        grad_in_valid = 1'b1; grad_in_data = 32'd55;
        #1;
        chk("empty_in_ready", grad_in_ready, 0);
        tick();
        chk("empty_no_valid", grad_out_valid, 0);
        fwd_valid = 1'b1; fwd_data = 32'd9;
        #1;
        chk("push_cycle_in_ready", grad_in_ready, 0);
        tick();
        fwd_valid = 1'b0;
        chk("push_cycle_no_valid", grad_out_valid, 0);
        #1;
        chk("after_push_in_ready", grad_in_ready, 1);
        tick();
        chk("after_push_valid", grad_out_valid, 1);
        chk("after_push_data", grad_out_data, 55);
        grad_in_valid = 1'b0;
        tick();

        // Backpressure
        for (int i = 1; i <= 3; i++) begin
            fwd_valid = 1'b1; fwd_data = DW'(i);
            tick();
        end
        fwd_valid = 1'b0;
        grad_in_valid = 1'b1; grad_in_data = 32'd11;
        tick();
        chk("bp_first_data", grad_out_data, 11);
        grad_out_ready = 1'b0; grad_in_data = 32'd12;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", grad_in_ready, 0);
            tick();
            chk("bp_hold_valid", grad_out_valid, 1);
            chk("bp_hold_data", grad_out_data, 11);
            chk("bp_count", count, 2);
        end
        grad_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", grad_in_ready, 1);
        tick();
        chk("bp_out12", grad_out_data, 12);
        grad_in_data = 32'd13;
        tick();
        chk("bp_out13", grad_out_data, 13);
        chk("bp_out13_valid", grad_out_valid, 1);
        grad_in_valid = 1'b0;
        tick();
        chk("bp_done_valid", grad_out_valid, 0);
        chk("bp_done_count", count, 0);

        // Simultaneous push/pop at count 1 and count 512, with pointer wrap
        fwd_valid = 1'b1; fwd_data = 32'h10; mq.push_back(1'b1);
        tick();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3000; i++) begin
                d = $urandom; g = $urandom;
                fwd_valid = 1'b1; fwd_data = d;
                grad_in_valid = 1'b1; grad_in_data = g;
                m = mq.pop_front();
                mq.push_back(~d[DW-1]);
                e = m ? g : '0;
                #1;
                chk("sim_readies", {fwd_ready, grad_in_ready}, 2'b11);
                tick();
                chk("sim_data", grad_out_data, e);
                chk("sim_count", count, (pass == 0) ? 1 : 512);
            end
            if (pass == 0) begin
                grad_in_valid = 1'b0;
                for (int i = 0; i < 511; i++) begin
                    d = $urandom;
                    fwd_valid = 1'b1; fwd_data = d;
                    mq.push_back(~d[DW-1]);
                    tick();
                end
                chk("sim_prefill512", count, 512);
            end
        end
        fwd_valid = 1'b0;
        for (int i = 0; i < 512; i++) begin
            g = $urandom;
            grad_in_valid = 1'b1; grad_in_data = g;
            m = mq.pop_front();
            e = m ? g : '0;
            tick();
            chk("sim_drain_data", grad_out_data, e);
        end
        grad_in_valid = 1'b0;
        tick();
        chk("sim_drain_empty", empty, 1);

        // Flush with a pending output
        for (int i = 0; i < 10; i++) begin
            fwd_valid = 1'b1; fwd_data = DW'(i + 1);
            tick();
        end
        fwd_valid = 1'b0;
        grad_out_ready = 1'b0;
        grad_in_valid = 1'b1; grad_in_data = 32'd77;
        tick();
        grad_in_valid = 1'b0;
        chk("fl_count9", count, 9);
        flush = 1'b1; fwd_valid = 1'b1; fwd_data = 32'd3;
        #1;
        chk("fl_fwd_ready", fwd_ready, 0);
        tick();
        flush = 1'b0; fwd_valid = 1'b0;
        chk("fl_count0", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_pending_valid", grad_out_valid, 1);
        chk("fl_pending_data", grad_out_data, 77);
        grad_out_ready = 1'b1;
        tick();
        chk("fl_delivered", grad_out_valid, 0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            fwd_valid = 1'b1; fwd_data = 32'd4;
            tick();
        end
        fwd_valid = 1'b0;
        grad_out_ready = 1'b0;
        grad_in_valid = 1'b1; grad_in_data = 32'd5;
        tick();
        grad_in_valid = 1'b0;
        chk("mid_pending", grad_out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", grad_out_valid, 0);
        chk("mid_rst_data", grad_out_data, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
